mmio_slave_bridge: RTL



---
 rtl/mmio_slave_bridge.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mmio_slave_bridge.sv
// Memory-mapped bridge: CPU stall-based data port to NUM_SLAVES peripheral
// pages plus one status page. Slave accesses use a registered enable/ready
// handshake with a per-access timeout that returns ERR_DATA and logs the error.
module mmio_slave_bridge #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [19:0] BASE_PAGE      = 20'h80000,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEADDEAD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_read,
  input  logic                     cpu_write,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_busywait,
  output logic [ADDR_WIDTH-1:0]    slv_address,
  output logic [31:0]              slv_write_data,
  output logic [NUM_SLAVES-1:0]    slv_read_enable,
  output logic [NUM_SLAVES-1:0]    slv_write_enable,
  input  logic [32*NUM_SLAVES-1:0] slv_read_data,
  input  logic [NUM_SLAVES-1:0]    slv_ready,
  output logic                     err_irq
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q;
  logic          op_wr_q;
  logic [31:0]   addr_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rdata_q;
  logic [15:0]   err_count_q;
  logic [31:0]   last_err_addr_q;
  logic          sticky_q;

  logic          req;
  logic          slave_hit;
  logic          status_hit;
  logic [2:0]    hit_idx;
  logic          sel_ready;
  logic [31:0]   sel_rdata;
  logic [31:0]   status_rdata;
  logic          timeout;
  logic          busy_raw;

  assign req     = cpu_read | cpu_write;
  assign timeout = (cnt_q == CNT_LAST);
  assign err_irq = sticky_q;

  // Address decode: which slave page, status page or nothing
  always_comb begin
    slave_hit = 1'b0;
    hit_idx   = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (cpu_addr[31:12] == BASE_PAGE + 20'(i)) begin
        slave_hit = 1'b1;
        hit_idx   = 3'(i);
      end
    end
    status_hit = (cpu_addr[31:12] == BASE_PAGE + 20'(NUM_SLAVES));
  end

  // Select ready and read data of the latched slave
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == 3'(i)) begin
        sel_ready = slv_ready[i];
        sel_rdata = slv_read_data[32*i +: 32];
      end
    end
  end

  // Status page read mux
  always_comb begin
    case (cpu_addr[3:0])
      4'h0:    status_rdata = {16'b0, err_count_q};
      4'h4:    status_rdata = last_err_addr_q;
      4'h8:    status_rdata = {31'b0, sticky_q};
      default: status_rdata = '0;
    endcase
  end

  // Next state, CPU stall and CPU read data
  always_comb begin
    state_d   = state_q;
    busy_raw  = 1'b0;
    cpu_rdata = '0;
    case (state_q)
      S_IDLE: begin
        if (req && (slave_hit || status_hit)) begin
          busy_raw = 1'b1;
          state_d  = slave_hit ? S_ACCESS : S_DONE;
        end
      end
      S_ACCESS: begin
        busy_raw = 1'b1;
        if (sel_ready || timeout) state_d = S_DONE;
      end
      S_DONE: begin
        cpu_rdata = rdata_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall is decoded combinationally from the request, so it is masked
  // while reset is held to keep the CPU port quiet during reset.
  assign cpu_busywait = busy_raw & rst_n;

  // Slave enables depend only on registered state
  always_comb begin
    slv_read_enable  = '0;
    slv_write_enable = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (state_q == S_ACCESS && idx_q == 3'(i)) begin
        slv_read_enable[i]  = ~op_wr_q;
        slv_write_enable[i] = op_wr_q;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request latching, timeout counting, data capture and error logging
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q           <= '0;
      op_wr_q         <= 1'b0;
      addr_q          <= '0;
      cnt_q           <= '0;
      rdata_q         <= '0;
      slv_address     <= '0;
      slv_write_data  <= '0;
      err_count_q     <= '0;
      last_err_addr_q <= '0;
      sticky_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req && slave_hit) begin
            idx_q          <= hit_idx;
            op_wr_q        <= cpu_write;
            addr_q         <= cpu_addr;
            slv_address    <= cpu_addr[ADDR_WIDTH-1:0];
            slv_write_data <= cpu_wdata;
            cnt_q          <= '0;
            rdata_q        <= '0;
          end else if (req && status_hit) begin
            rdata_q <= cpu_write ? '0 : status_rdata;
            if (cpu_write && cpu_addr[3:0] == 4'h8 && cpu_wdata[0]) begin
              sticky_q    <= 1'b0;
              err_count_q <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (sel_ready) begin
            if (!op_wr_q) rdata_q <= sel_rdata;
          end else if (timeout) begin
            if (!op_wr_q) rdata_q <= ERR_DATA;
            sticky_q        <= 1'b1;
            last_err_addr_q <= addr_q;
            if (err_count_q != '1) err_count_q <= err_count_q + 16'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
